hash_msg_feeder: RTL and testbench



---
 rtl/hash_feeder_pkg.sv | 20 ++
 rtl/feeder_byte_buffer.sv | 24 ++
 rtl/hash_msg_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_hash_msg_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_feeder_pkg.sv
// Shared types and constants for the hash core message feeder.
package hash_feeder_pkg;

    localparam int unsigned DEF_MAX_LEN    = 64;
    localparam int unsigned DEF_TMO_MARGIN = 8;
    localparam int unsigned CNT_W          = 64;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Width of the length register: holds 0..max_len inclusive.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/feeder_byte_buffer.sv
// Byte register array: one synchronous write port, one asynchronous read port.
module feeder_byte_buffer #(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata_c
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/hash_msg_feeder.sv
// Store-and-forward byte buffer that replays each message to the hash core as one unbroken burst.
// Optional WAIT watchdog enabled by defining HASH_FEEDER_TIMEOUT_EN.
module hash_msg_feeder
    import hash_feeder_pkg::*;
#(
    parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
    parameter int unsigned TMO_MARGIN = DEF_TMO_MARGIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic             in_null,
    output logic             M_valid,
    output logic [7:0]       message,
    output logic [CNT_W-1:0] counter,
    input  logic             hash_ready,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_tmo
);

    localparam int unsigned    AW      = $clog2(MAX_LEN);
    localparam int unsigned    LEN_W   = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LEN_W-1:0]   r_rd, w_rd_nxt;
    logic               r_in_ready, w_in_ready_nxt;
    logic               r_m_valid, w_m_valid_nxt;
    logic [7:0]         r_message, w_message_nxt;
    logic [CNT_W-1:0]   r_counter, w_counter_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_err_ovf, w_err_ovf_nxt;
    logic               r_hr_q;
    logic               w_hr_rise;
    logic               w_accept;
    logic               w_we;
    logic [AW-1:0]      w_raddr;
    logic [7:0]         w_rdata;

`ifdef HASH_FEEDER_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(TMO_MARGIN + 4);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MARGIN + 3);

    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             r_err_tmo, w_err_tmo_nxt;
`else
    localparam int unsigned unused_tmo_margin = TMO_MARGIN;
`endif

    assign w_accept  = in_valid & r_in_ready;
    assign w_hr_rise = hash_ready & ~r_hr_q;
    assign w_raddr   = (r_state == ST_SEND) ? r_rd[AW-1:0] : '0;

    feeder_byte_buffer #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (r_len[AW-1:0]),
        .i_wdata   (in_byte),
        .i_raddr   (w_raddr),
        .o_rdata_c (w_rdata)
    );

    // Next-state and next-output logic; registered outputs are loaded from the *_nxt values.
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_rd_nxt      = r_rd;
        w_m_valid_nxt = 1'b0;
        w_message_nxt = r_message;
        w_counter_nxt = r_counter;
        w_err_ovf_nxt = 1'b0;
        w_we          = 1'b0;
`ifdef HASH_FEEDER_TIMEOUT_EN
        w_tmo_nxt     = r_tmo;
        w_err_tmo_nxt = 1'b0;
`endif

        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    if (in_last && in_null) begin
                        w_len_nxt     = '0;
                        w_state_nxt   = ST_SEND;
                        w_m_valid_nxt = 1'b1;
                        w_message_nxt = 8'h00;
                        w_counter_nxt = '0;
                        w_rd_nxt      = LEN_W'(1);
                    end else if (r_len == LEN_MAX) begin
                        w_err_ovf_nxt = 1'b1;
                        if (in_last) begin
                            w_len_nxt = '0;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end else begin
                        w_we      = 1'b1;
                        w_len_nxt = r_len + LEN_W'(1);
                        if (in_last) begin
                            // First burst byte bypasses the buffer when it is being written this edge.
                            w_state_nxt   = ST_SEND;
                            w_m_valid_nxt = 1'b1;
                            w_message_nxt = (r_len == '0) ? in_byte : w_rdata;
                            w_counter_nxt = CNT_W'(w_len_nxt);
                            w_rd_nxt      = LEN_W'(1);
                        end
                    end
                end
            end
            ST_SEND: begin
                if (r_rd < r_len) begin
                    w_m_valid_nxt = 1'b1;
                    w_message_nxt = w_rdata;
                    w_rd_nxt      = r_rd + LEN_W'(1);
                end else begin
                    w_state_nxt = ST_WAIT;
`ifdef HASH_FEEDER_TIMEOUT_EN
                    w_tmo_nxt   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (w_hr_rise) begin
                    w_len_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end
`ifdef HASH_FEEDER_TIMEOUT_EN
                else if (r_tmo == TMO_LAST) begin
                    w_err_tmo_nxt = 1'b1;
                    w_len_nxt     = '0;
                    w_state_nxt   = ST_FILL;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
`endif
            end
            ST_DROP: begin
                if (w_accept && in_last) begin
                    w_len_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == ST_FILL) || (w_state_nxt == ST_DROP);
        w_busy_nxt     = (w_state_nxt != ST_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_len      <= '0;
            r_rd       <= '0;
            r_in_ready <= 1'b0;
            r_m_valid  <= 1'b0;
            r_message  <= '0;
            r_counter  <= '0;
            r_busy     <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_hr_q     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_rd       <= w_rd_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_message  <= w_message_nxt;
            r_counter  <= w_counter_nxt;
            r_busy     <= w_busy_nxt;
            r_err_ovf  <= w_err_ovf_nxt;
            r_hr_q     <= hash_ready;
        end
    end

`ifdef HASH_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo     <= '0;
            r_err_tmo <= 1'b0;
        end else begin
            r_tmo     <= w_tmo_nxt;
            r_err_tmo <= w_err_tmo_nxt;
        end
    end

    assign err_tmo = r_err_tmo;
`else
    assign err_tmo = 1'b0;
`endif

    assign in_ready = r_in_ready;
    assign M_valid  = r_m_valid;
    assign message  = r_message;
    assign counter  = r_counter;
    assign busy     = r_busy;
    assign err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Self-checking bench for hash_msg_feeder: directed scenarios plus randomized messages vs. a queue model.
module tb_hash_msg_feeder;

    localparam int unsigned MAX_LEN    = 8;
    localparam int unsigned TMO_MARGIN = 8;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_null;
    logic        M_valid;
    logic [7:0]  message;
    logic [63:0] counter;
    logic        hash_ready;
    logic        busy;
    logic        err_ovf;
    logic        err_tmo;

    int n_checks = 0;
    int n_fail   = 0;

    hash_msg_feeder #(
        .MAX_LEN    (MAX_LEN),
        .TMO_MARGIN (TMO_MARGIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .in_last    (in_last),
        .in_null    (in_null),
        .M_valid    (M_valid),
        .message    (message),
        .counter    (counter),
        .hash_ready (hash_ready),
        .busy       (busy),
        .err_ovf    (err_ovf),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected burst is the message itself (or a single 0x00 for a null message).
    task automatic check_burst(input byte_q_t exp, input int exp_len, input int rst_at);
        for (int k = 0; k < exp.size(); k++) begin
            if (k == rst_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                check_eq("rst_m_valid", M_valid, 0);
                check_eq("rst_in_ready", in_ready, 0);
                check_eq("rst_counter", counter, 0);
                check_eq("rst_message", message, 0);
                check_eq("rst_busy", busy, 0);
                return;
            end
            check_eq("burst_valid", M_valid, 1);
            check_eq("burst_byte", message, exp[k]);
            check_eq("burst_counter", counter, 64'(exp_len));
            check_eq("send_in_ready", in_ready, 0);
            in_valid = 1'($urandom_range(1));
            in_last  = 1'b1;
            in_null  = 1'($urandom_range(1));
            tick();
        end
        in_valid = 1'b0;
        check_eq("burst_end", M_valid, 0);
        check_eq("wait_busy", busy, 1);
        check_eq("wait_in_ready", in_ready, 0);
    endtask

    task automatic send_msg(input byte_q_t msg, input bit is_null, input int rst_at);
        int      n;
        int      i;
        int      guard;
        bit      ovf;
        byte_q_t exp;
        n     = is_null ? 1 : msg.size();
        i     = 0;
        guard = 0;
        ovf   = !is_null && (n > int'(MAX_LEN));
        while (i < n) begin
            bit v;
            bit acc;
            v        = ($urandom_range(3) != 0);
            in_valid = v;
            in_byte  = is_null ? 8'($urandom) : msg[i];
            in_last  = (i == n - 1);
            in_null  = is_null;
            acc      = v && in_ready;
            tick();
            in_valid = 1'b0;
            if (acc) begin
                check_eq("err_ovf", err_ovf, 64'(!is_null && i == int'(MAX_LEN)));
                if (!(i == n - 1 && !ovf)) check_eq("in_ready_hold", in_ready, 1);
                i++;
                guard = 0;
            end else begin
                guard++;
                if (guard > 50) begin
                    check_eq("accept_timeout", 0, 1);
                    return;
                end
            end
        end
        if (ovf) begin
            check_eq("ovf_no_burst", M_valid, 0);
            check_eq("ovf_busy", busy, 0);
        end else if (is_null) begin
            exp.push_back(8'h00);
            check_burst(exp, 0, rst_at);
        end else begin
            check_burst(msg, n, rst_at);
        end
    endtask

    // Completes WAIT with a fresh hash_ready rising edge; a stale high level must first be held off.
    task automatic finish_hash(input bit keep_high);
        if (hash_ready) begin
            repeat (3) begin
                tick();
                check_eq("stale_hold", in_ready, 0);
            end
            hash_ready = 1'b0;
            tick();
            check_eq("fall_hold", in_ready, 0);
        end else begin
            repeat ($urandom_range(2)) begin
                tick();
                check_eq("wait_hold", in_ready, 0);
            end
        end
        hash_ready = 1'b1;
        tick();
        check_eq("ready_after_rise", in_ready, 1);
        check_eq("busy_after_rise", busy, 0);
        if (!keep_high) hash_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t m;
        bit      saw;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        in_last    = 1'b0;
        in_null    = 1'b0;
        hash_ready = 1'b0;
        tick();
        tick();
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_m_valid", M_valid, 0);
        check_eq("reset_message", message, 0);
        check_eq("reset_counter", counter, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_err_ovf", err_ovf, 0);
        check_eq("reset_err_tmo", err_tmo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_in_ready", in_ready, 1);

        // Normal "abc" message, leave hash_ready high
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, -1);
        finish_hash(1'b1);

        // Second message while hash_ready is stale-high
        m.delete();
        for (int j = 0; j < 5; j++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, -1);
        finish_hash(1'b0);

        // Zero-length message
        m.delete();
        send_msg(m, 1'b1, -1);
        finish_hash(1'b0);

        // Overflow then a short message
        m.delete();
        for (int j = 0; j < int'(MAX_LEN) + 2; j++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, -1);
        m = {8'hA5, 8'h5A};
        send_msg(m, 1'b0, -1);
        finish_hash(1'b0);

        // Exactly full buffer
        m.delete();
        for (int j = 0; j < int'(MAX_LEN); j++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, -1);
        finish_hash(1'b0);

        // Reset during the second burst cycle
        m.delete();
        for (int j = 0; j < 8; j++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rst_release_in_ready", in_ready, 1);
        check_eq("rst_release_m_valid", M_valid, 0);
        m = {8'h3C};
        send_msg(m, 1'b0, -1);
        finish_hash(1'b0);

        // Watchdog behaviour with hash_ready held low
        m = {8'h11, 8'h22, 8'h33};
        send_msg(m, 1'b0, -1);
`ifdef HASH_FEEDER_TIMEOUT_EN
        check_eq("tmo_first_wait", err_tmo, 0);
        repeat (TMO_MARGIN + 3) begin
            tick();
            check_eq("tmo_early", err_tmo, 0);
        end
        tick();
        check_eq("tmo_pulse", err_tmo, 1);
        check_eq("tmo_in_ready", in_ready, 1);
        tick();
        check_eq("tmo_one_cycle", err_tmo, 0);
`else
        saw = 1'b0;
        repeat (3 * TMO_MARGIN) begin
            tick();
            saw |= err_tmo;
        end
        check_eq("tmo_absent", 64'(saw), 0);
        check_eq("wait_unbounded", in_ready, 0);
        finish_hash(1'b0);
`endif

        // Randomized messages against the queue model
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(MAX_LEN + 3);
            m.delete();
            for (int j = 0; j < len; j++) m.push_back(8'($urandom));
            send_msg(m, (len == 0), -1);
            if (len <= int'(MAX_LEN)) finish_hash(1'($urandom_range(1)));
            repeat ($urandom_range(2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
